// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin packet arbiter that merges NUM_PORTS AXI-Stream byte sources into one UART TX byte stream.
// Define AXIS_UART_TX_ARB_HEADER_EN to prefix every packet with the header byte 8'h80 + grant_id.
module axis_uart_tx_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_PORTS-1:0]   s_tvalid,
  output logic [NUM_PORTS-1:0]   s_tready,
  input  logic [NUM_PORTS*8-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]   s_tlast,
  output logic                   txbyte_tvalid,
  input  logic                   txbyte_tready,
  output logic [7:0]             txbyte_tdata,
  output logic                   txbyte_tkeep,
  output logic [2:0]             grant_id,
  output logic                   busy
);

`ifdef AXIS_UART_TX_ARB_HEADER_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_STREAM} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM} state_e;
`endif

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;

  logic       out_free;
  logic       streaming;
  logic       beat_fire;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       rr_found;
  logic [2:0] rr_pick;
  int         rr_dist;

  // The output register can take a new byte when empty or when its byte leaves this cycle.
  assign out_free  = !out_valid_q || txbyte_tready;
  assign streaming = (state_q == ST_STREAM);
  assign beat_fire = streaming && out_free && sel_valid;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_tready  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid   = s_tvalid[i];
        sel_last    = s_tlast[i];
        sel_data    = s_tdata[8*i +: 8];
        s_tready[i] = streaming && out_free;
      end
    end
  end

  // Round-robin: distance of port i above last_grant (1..NUM_PORTS); the smallest requesting distance wins.
  always_comb begin
    rr_dist = NUM_PORTS + 1;
    rr_pick = last_grant_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (s_tvalid[i] &&
          ((i + NUM_PORTS - 1 - int'(last_grant_q)) % NUM_PORTS) + 1 < rr_dist) begin
        rr_dist = ((i + NUM_PORTS - 1 - int'(last_grant_q)) % NUM_PORTS) + 1;
        rr_pick = 3'(i);
      end
    end
    rr_found = (rr_dist <= NUM_PORTS);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (out_valid_q && txbyte_tready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d      = rr_pick;
          last_grant_d = rr_pick;
`ifdef AXIS_UART_TX_ARB_HEADER_EN
          state_d      = ST_HEADER;
`else
          state_d      = ST_STREAM;
`endif
        end
      end
`ifdef AXIS_UART_TX_ARB_HEADER_EN
      ST_HEADER: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h80 + {5'd0, grant_q};
          state_d     = ST_STREAM;
        end
      end
`endif
      ST_STREAM: begin
        if (beat_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          if (sel_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_PORTS - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign txbyte_tvalid = out_valid_q;
  assign txbyte_tdata  = out_data_q;
  assign txbyte_tkeep  = 1'b1;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: a packet-level round-robin model predicts the output byte order.
// Build with AXIS_UART_TX_ARB_HEADER_EN defined to exercise the per-packet header byte.
module tb_axis_uart_tx_arbiter;
  localparam int NP = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NP-1:0]   s_tvalid;
  logic [NP-1:0]   s_tready;
  logic [NP*8-1:0] s_tdata;
  logic [NP-1:0]   s_tlast;
  logic            txbyte_tvalid;
  logic            txbyte_tready;
  logic [7:0]      txbyte_tdata;
  logic            txbyte_tkeep;
  logic [2:0]      grant_id;
  logic            busy;

  always #5 aclk = ~aclk;

  axis_uart_tx_arbiter #(.NUM_PORTS(NP)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tlast       (s_tlast),
    .txbyte_tvalid (txbyte_tvalid),
    .txbyte_tready (txbyte_tready),
    .txbyte_tdata  (txbyte_tdata),
    .txbyte_tkeep  (txbyte_tkeep),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  // Per-port pending beats: data, last flag, idle cycles before the beat is presented.
  logic [7:0] bq [NP][$];
  logic       lq [NP][$];
  int         dq [NP][$];
  logic [7:0] exp_q [$];
  int         out_cyc [$];
  logic [7:0] out_byte [$];

  int            cyc = 0;
  int            model_last = NP - 1;
  int            tready_mode = 0;
  int            stall_cnt = 0;
  logic          stall_done = 1'b0;
  int            accepted = 0;
  logic          hold_chk = 1'b0;
  int            wait_cnt [NP];
  logic          beat_live [NP];
  logic [NP-1:0] fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks that stalled bytes hold.
  logic       pend_v = 1'b0;
  logic [7:0] pend_d = '0;
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        pend_v = 1'b0;
      end else begin
        if (pend_v) begin
          check("stall_hold_valid", {31'd0, txbyte_tvalid}, 32'd1);
          check("stall_hold_data", {24'd0, txbyte_tdata}, {24'd0, pend_d});
        end
        if (txbyte_tvalid && txbyte_tready) begin
          out_cyc.push_back(cyc);
          out_byte.push_back(txbyte_tdata);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got 0x%0h, expected no byte (t=%0t)", txbyte_tdata, $time);
          end else begin
            check("tx_byte", {24'd0, txbyte_tdata}, {24'd0, exp_q.pop_front()});
          end
        end
        pend_v = txbyte_tvalid && !txbyte_tready;
        pend_d = txbyte_tdata;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic queues_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < NP; i++) if (bq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic add_pkt(input int p, input int len, input logic [7:0] base, input logic [7:0] stride,
                         input int gap_at, input int gap_len);
    for (int b = 0; b < len; b++) begin
      bq[p].push_back(8'(base + b * stride));
      lq[p].push_back(b == len - 1);
      dq[p].push_back(b == gap_at ? gap_len : 0);
    end
  endtask

  // Packet-level model: grant the next port (round-robin) that still has a packet, emit it whole.
  task automatic model_compute();
    int   ptr [NP];
    int   last;
    int   p;
    logic more;
    for (int i = 0; i < NP; i++) ptr[i] = 0;
    last = model_last;
    do begin
      more = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        p = (last + k) % NP;
        if (!more && ptr[p] < bq[p].size()) begin
          more = 1'b1;
          last = p;
`ifdef AXIS_UART_TX_ARB_HEADER_EN
          exp_q.push_back(8'(8'h80 + p));
`endif
          do begin
            exp_q.push_back(bq[p][ptr[p]]);
            ptr[p]++;
          end while (!lq[p][ptr[p]-1]);
        end
      end
    end while (more);
    model_last = last;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (bq[i].size() != 0) begin
        if (!beat_live[i]) begin
          wait_cnt[i]  = dq[i][0];
          beat_live[i] = 1'b1;
        end
        if (wait_cnt[i] > 0) begin
          wait_cnt[i]--;
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end else begin
          s_tvalid[i]        = 1'b1;
          s_tdata[8*i +: 8]  = bq[i][0];
          s_tlast[i]         = lq[i][0];
        end
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
    case (tready_mode)
      0: txbyte_tready = 1'b1;
      1: txbyte_tready = ($urandom_range(0, 3) != 0);
      default: begin
        if (stall_cnt > 0) begin
          stall_cnt--;
          txbyte_tready = 1'b0;
        end else if (!stall_done && txbyte_tvalid && txbyte_tdata == 8'h5A) begin
          stall_done    = 1'b1;
          stall_cnt     = 19;
          txbyte_tready = 1'b0;
        end else begin
          txbyte_tready = 1'b1;
        end
      end
    endcase
  endtask

  // One clock: sample handshakes mid-cycle, retire accepted beats after the edge, drive the next inputs.
  task automatic step();
    @(negedge aclk);
    fire = s_tvalid & s_tready;
    if (!busy) check("idle_no_sready", {28'd0, s_tready}, 32'd0);
    if (hold_chk && busy && bq[2].size() != 0) begin
      check("grant_held_p2", {29'd0, grant_id}, 32'd2);
      check("p1_not_ready", {31'd0, s_tready[1]}, 32'd0);
    end
    if (tready_mode == 2 && txbyte_tvalid && !txbyte_tready)
      check("stall_sready_low", {28'd0, s_tready}, 32'd0);
    @(posedge aclk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (fire[i]) begin
        void'(bq[i].pop_front());
        void'(lq[i].pop_front());
        void'(dq[i].pop_front());
        beat_live[i] = 1'b0;
        accepted++;
      end
    end
    drive();
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NP; i++) begin
      bq[i].delete();
      lq[i].delete();
      dq[i].delete();
      beat_live[i] = 1'b0;
      wait_cnt[i]  = 0;
    end
    exp_q.delete();
    s_tvalid = '0;
    s_tlast  = '0;
    #2;
    check("rst_txvalid", {31'd0, txbyte_tvalid}, 32'd0);
    check("rst_txdata", {24'd0, txbyte_tdata}, 32'd0);
    check("rst_sready", {28'd0, s_tready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {29'd0, grant_id}, 32'd0);
    check("rst_tkeep", {31'd0, txbyte_tkeep}, 32'd1);
    @(posedge aclk);
    #1;
    aresetn    = 1'b1;
    model_last = NP - 1;
    #1;
    check("post_rst_txvalid", {31'd0, txbyte_tvalid}, 32'd0);
  endtask

  task automatic run_phase(input string name, input int tmode, input int rst_at);
    logic done;
    model_compute();
    tready_mode = tmode;
    stall_cnt   = 0;
    stall_done  = 1'b0;
    accepted    = 0;
    drive();
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (rst_at >= 0 && accepted == rst_at) begin
        apply_reset();
        done = 1'b1;
      end else if (queues_empty() && exp_q.size() == 0) begin
        done = 1'b1;
      end else begin
        step();
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
      for (int i = 0; i < NP; i++) begin
        bq[i].delete();
        lq[i].delete();
        dq[i].delete();
        beat_live[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int base;
    int cnt;
    int npk;
    int len;
    aresetn       = 1'b1;
    s_tvalid      = '0;
    s_tdata       = '0;
    s_tlast       = '0;
    txbyte_tready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      beat_live[i] = 1'b0;
      wait_cnt[i]  = 0;
    end
    #1;
    apply_reset();

    // Port 0 alone, two bytes at full rate.
    base = out_byte.size();
    add_pkt(0, 2, 8'h11, 8'h11, -1, 0);
    run_phase("p0_basic", 0, -1);
    check("p0_out_count", 32'(out_byte.size() - base), 32'(exp_len_basic()));
    if (out_byte.size() >= base + 2)
      check("p0_back_to_back", 32'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-2]), 32'd1);
    check("p0_grant", {29'd0, grant_id}, 32'd0);

    // All four ports at once, from reset priority.
    apply_reset();
    for (int p = 0; p < NP; p++) add_pkt(p, 3, 8'(8'h01 + 16 * p), 8'h01, -1, 0);
    run_phase("all_ports", 1, -1);
    check("all_ports_grant", {29'd0, grant_id}, 32'd3);

    // Single-beat packet on port 1, then port 2 (stalling mid-packet) versus port 1.
    add_pkt(1, 1, 8'hC1, 8'h00, -1, 0);
    run_phase("single_beat", 0, -1);
    check("single_beat_grant", {29'd0, grant_id}, 32'd1);
    add_pkt(2, 3, 8'hA0, 8'h01, 1, 10);
    add_pkt(1, 2, 8'hB0, 8'h01, -1, 0);
    hold_chk = 1'b1;
    run_phase("p2_hold", 0, -1);
    hold_chk = 1'b0;

    // Output back-pressure for 20 cycles on 0x5A.
    base = out_byte.size();
    add_pkt(0, 2, 8'h5A, 8'h11, -1, 0);
    run_phase("stall_5a", 2, -1);
    cnt = 0;
    for (int i = base; i < out_byte.size(); i++) if (out_byte[i] == 8'h5A) cnt++;
    check("one_5a_emitted", 32'(cnt), 32'd1);

    // Reset in the middle of a 4-byte packet, then a clean restart from port 0.
    add_pkt(2, 4, 8'h40, 8'h01, -1, 0);
    run_phase("mid_rst", 0, 1);
    add_pkt(3, 2, 8'hD0, 8'h01, -1, 0);
    add_pkt(0, 2, 8'hE0, 8'h01, -1, 0);
    run_phase("after_rst", 1, -1);
    check("after_rst_grant", {29'd0, grant_id}, 32'd3);

    // Randomized traffic with mid-packet gaps and random back-pressure.
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NP; p++) begin
        npk = $urandom_range(0, 2);
        for (int k = 0; k < npk; k++) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) begin
            bq[p].push_back(8'($urandom));
            lq[p].push_back(b == len - 1);
            dq[p].push_back((b == 0 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
          end
        end
      end
      run_phase("random", 1, -1);
    end

`ifdef AXIS_UART_TX_ARB_HEADER_EN
    apply_reset();
    base = out_byte.size();
    add_pkt(3, 1, 8'hAB, 8'h00, -1, 0);
    run_phase("header", 0, -1);
    if (out_byte.size() >= base + 2) begin
      check("header_byte", {24'd0, out_byte[base]}, 32'h83);
      check("header_payload", {24'd0, out_byte[base+1]}, 32'hAB);
    end else begin
      check("header_out_count", 32'(out_byte.size() - base), 32'd2);
    end
`endif

    repeat (3) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bytes expected from the two-byte port-0 packet, including the optional header.
  function automatic int exp_len_basic();
`ifdef AXIS_UART_TX_ARB_HEADER_EN
    return 3;
`else
    return 2;
`endif
  endfunction

endmodule

// File: doc/axis_uart_tx_arbiter.md
AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of packet requesters sharing one UART TX byte channel, legal range 2..8.
REQ-002 SHALL have port aclk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_tvalid  input  NUM_PORTS  per-requester beat valid.
REQ-005 SHALL have port s_tready  output  NUM_PORTS  per-requester beat ready.
REQ-006 SHALL have port s_tdata  input  NUM_PORTS*8  per-requester byte; port i occupies bits [8i+7:8i].
REQ-007 SHALL have port s_tlast  input  NUM_PORTS  per-requester end-of-packet.
REQ-008 SHALL have port txbyte_tvalid  output  1  byte valid toward UART transmitter.
REQ-009 SHALL have port txbyte_tready  input  1  byte ready from UART transmitter.
REQ-010 SHALL have port txbyte_tdata  output  8  byte toward UART transmitter.
REQ-011 SHALL have port txbyte_tkeep  output  1  byte keep; constant 1.
REQ-012 SHALL have port grant_id  output  3  index of the current or last granted port.
REQ-013 SHALL have port busy  output  1  high while any state other than IDLE is active.

Function
REQ-014 SHALL implement states IDLE, HEADER, STREAM; arbitration occurs only in IDLE.
REQ-015 SHALL grant, in an IDLE cycle with any s_tvalid high, the first requesting port found searching upward from last_grant+1 modulo NUM_PORTS (round-robin).
REQ-016 SHALL register the grant in the same edge as the IDLE->HEADER (macro defined) or IDLE->STREAM (macro undefined) transition; no s_tready is high in IDLE.
REQ-017 SHALL hold the grant for a whole packet; other requesters' s_tvalid are ignored until the granted port's tlast beat is accepted.
REQ-018 SHALL drive s_tready[grant_id] = STREAM and (!txbyte_tvalid or txbyte_tready); all other s_tready bits 0.
REQ-019 SHALL load s_tdata of the granted port into an output register on each accepted beat; txbyte_tvalid rises the cycle after acceptance (one cycle latency).
REQ-020 SHALL keep txbyte_tvalid and txbyte_tdata stable until txbyte_tready is sampled high; txbyte_tvalid never depends combinationally on txbyte_tready.
REQ-021 SHALL sustain one byte per cycle when txbyte_tready stays high and the granted source stays valid.
REQ-022 SHALL, on acceptance of a beat with s_tlast high, return to IDLE at that edge; the next grant may occur in the following cycle, while the last byte is still pending in the output register.
REQ-023 SHALL drop neither bytes nor packets when a granted source deasserts tvalid mid-packet; the grant is held indefinitely.
REQ-024 SHALL treat a single-beat packet (tlast on the first beat) as a complete packet.

Reset
REQ-025 SHALL on aresetn low drive txbyte_tvalid=0, txbyte_tdata=0, s_tready=0, busy=0, grant_id=0, state=IDLE, last_grant=NUM_PORTS-1, so port 0 has first priority.
REQ-026 SHALL on reset mid-packet discard the packet and any pending output byte; no tail bytes are emitted after release.
REQ-027 SHALL have txbyte_tkeep=1 at all times, including during reset.

Configuration
REQ-028 SHALL honour macro AXIS_UART_TX_ARB_HEADER_EN: when defined, the HEADER state loads the byte 8'h80+grant_id into the output register once it is free, then moves to STREAM; s_tready stays 0 during HEADER.
REQ-029 SHALL, without AXIS_UART_TX_ARB_HEADER_EN, omit the HEADER state and the header byte entirely, transitioning IDLE->STREAM.

Verification
REQ-030 SHALL verify: after reset, s_tvalid=4'b0001, port 0 sends 0x11,0x22 (tlast) with txbyte_tready=1 -> output 0x11,0x22 on consecutive cycles, grant_id=0.
REQ-031 SHALL verify: all four ports present one 3-byte packet simultaneously -> packets emitted in order 0,1,2,3, never interleaved.
REQ-032 SHALL verify: port 2 is granted and its tvalid drops for 10 cycles mid-packet while port 1 requests -> port 1 is not granted until port 2's tlast is accepted.
REQ-033 SHALL verify: txbyte_tready held low for 20 cycles while holding 0x5A -> txbyte_tdata stays 0x5A, exactly one 0x5A is emitted, s_tready stays low.
REQ-034 SHALL verify: aresetn pulsed low during byte 2 of a 4-byte packet -> txbyte_tvalid=0 after reset, next packet begins cleanly from port 0.
REQ-035 SHALL verify, with AXIS_UART_TX_ARB_HEADER_EN defined: port 3 packet 0xAB (tlast) -> output 0x83 then 0xAB.
